move_collector: RTL and testbench

Serialises the 16 per-square move words produced by a `square` instance into a single move stream for the search/move-list stage. It accepts one 16-word bundle per square and drops empty words. It emits captures before quiet moves, one per cycle, under a valid/ready handshake, and reports the total move count when the last square of a board scan has drained.

---
 rtl/chess_move_pkg.sv | 35 +++
 rtl/lsb_pick16.sv | 17 +
 rtl/move_collector.sv | 143 ++++++++++++++
 tb/tb_move_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_move_pkg.sv
// Shared definitions for the move-generation pipeline:
// move word layout, direction indices and collector states.
package chess_move_pkg;

    localparam int MOVE_W    = 32;

    localparam int FROM_LO   = 12;
    localparam int CAPT_LO   = 18;
    localparam int CAPT_HI   = 23;
    localparam int CASTLE_LO = 24;

    localparam int DIR_U   = 0;
    localparam int DIR_D   = 1;
    localparam int DIR_L   = 2;
    localparam int DIR_R   = 3;
    localparam int DIR_UL  = 4;
    localparam int DIR_UR  = 5;
    localparam int DIR_DL  = 6;
    localparam int DIR_DR  = 7;
    localparam int DIR_UUL = 8;
    localparam int DIR_UUR = 9;
    localparam int DIR_LLU = 10;
    localparam int DIR_RRU = 11;
    localparam int DIR_DDL = 12;
    localparam int DIR_DDR = 13;
    localparam int DIR_LLD = 14;
    localparam int DIR_RRD = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } collector_state_t;

endpackage

// File: rtl/lsb_pick16.sv
// Lowest-set-bit priority encoder over a 16-bit request.
// Ports: req (in), found (out, any bit set), idx (out, lowest set index).
module lsb_pick16 (
    input  logic [15:0] req,
    output logic        found,
    output logic [3:0]  idx
);

    always_comb begin
        found = |req;
        idx   = '0;
        for (int i = 15; i >= 0; i--) begin
            if (req[i]) idx = 4'(i);
        end
    end

endmodule

// File: rtl/move_collector.sv
// Serialises one 16-word move bundle per square into a move stream,
// captures first, and reports the move count at the end of a scan.
// Ports: clk, rst_n, flush; in_valid/in_ready/in_last/in_moves bundle
// input; out_valid/out_ready/out_move/out_dir/out_capture move output;
// list_done pulse with move_count.
module move_collector #(
    parameter int MOVE_W = 32,
    parameter int NDIR   = 16,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [NDIR*MOVE_W-1:0] in_moves,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [MOVE_W-1:0]      out_move,
    output logic [3:0]             out_dir,
    output logic                   out_capture,
    output logic                   list_done,
    output logic [CNT_W-1:0]       move_count
);
    import chess_move_pkg::*;

    localparam int CAPT_W = CAPT_HI - CAPT_LO + 1;

    collector_state_t state, state_nx;

    logic [MOVE_W-1:0] words [NDIR];
    logic [NDIR-1:0]   pend, capt;
    logic [NDIR-1:0]   in_mv, in_cp;
    logic [NDIR-1:0]   sel_hot;
    logic              last_q;
    logic [CNT_W-1:0]  cnt;

    logic       cap_found, any_found;
    logic [3:0] cap_idx, any_idx, sel;
    logic       accept, take, drained;

    always_comb begin
        in_mv = '0;
        in_cp = '0;
        for (int k = 0; k < NDIR; k++) begin
            in_mv[k] = |in_moves[k*MOVE_W +: MOVE_W];
            in_cp[k] = |in_moves[k*MOVE_W+CAPT_LO +: CAPT_W];
        end
    end

    lsb_pick16 u_pick_capt (
        .req   (pend & capt),
        .found (cap_found),
        .idx   (cap_idx)
    );

    lsb_pick16 u_pick_pend (
        .req   (pend),
        .found (any_found),
        .idx   (any_idx)
    );

    assign sel = cap_found ? cap_idx : any_idx;

    always_comb begin
        sel_hot      = '0;
        sel_hot[sel] = 1'b1;
    end

    assign accept  = (state == IDLE) && in_valid && !flush;
    assign take    = (state == DRAIN) && out_ready;
    // Bundle finishes when the bit being consumed is the only one left.
    assign drained = ((pend & ~sel_hot) == '0);

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        list_done = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (|in_mv)       state_nx = DRAIN;
                    else if (in_last) state_nx = DONE;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && drained)
                    state_nx = last_q ? DONE : IDLE;
            end
            DONE: begin
                list_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    assign out_move    = out_valid ? words[sel] : '0;
    assign out_dir     = out_valid ? sel : 4'd0;
    assign out_capture = out_valid & capt[sel];
    assign move_count  = cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pend   <= '0;
            capt   <= '0;
            last_q <= 1'b0;
            cnt    <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                pend <= '0;
                capt <= '0;
                cnt  <= '0;
            end else if (accept) begin
                pend   <= in_mv;
                capt   <= in_cp & in_mv;
                last_q <= in_last;
            end else if (take) begin
                pend <= pend & ~sel_hot;
                capt <= capt & ~sel_hot;
                if (cnt != '1) cnt <= cnt + 1'b1;
            end else if (state == DONE) begin
                cnt <= '0;
            end
        end
    end

    // Word payload is only visible through the pend mask, so no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < NDIR; k++)
                words[k] <= in_moves[k*MOVE_W +: MOVE_W];
        end
    end

endmodule

// File: tb/tb_move_collector.sv
// Randomised bench for move_collector against a queue-based model:
// captures in ascending direction order, then quiet moves.
module tb_move_collector;

    logic         clk = 1'b0;
    logic         rst_n, flush, in_valid, in_ready, in_last;
    logic [511:0] in_moves;
    logic         out_valid, out_ready, out_capture, list_done;
    logic [31:0]  out_move;
    logic [3:0]   out_dir;
    logic [7:0]   move_count;

    int errors = 0;
    int checks = 0;
    int model_cnt = 0;
    logic [31:0] rdy_pat = 32'hFFFF_FFF9;

    typedef struct {
        logic [31:0] mv;
        logic [3:0]  dir;
        logic        cap;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    move_collector #(.MOVE_W(32), .NDIR(16), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .in_moves    (in_moves),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_move    (out_move),
        .out_dir     (out_dir),
        .out_capture (out_capture),
        .list_done   (list_done),
        .move_count  (move_count)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rand_word(input int p_move,
                                              input bit cap);
        logic [31:0] w;
        if (int'($urandom_range(99)) >= p_move) return 32'd0;
        w = $urandom;
        if (cap) w[23:18] = 6'($urandom_range(63, 1));
        else     w[23:18] = 6'd0;
        if (w == 32'd0) w = 32'd1;
        return w;
    endfunction

    function automatic void bump();
        if (model_cnt < 255) model_cnt++;
    endfunction

    task automatic build_expect(input logic [511:0] b);
        logic [31:0] w;
        exp_t e;
        q.delete();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 16; k++) begin
                w = b[k*32 +: 32];
                e.mv  = w;
                e.dir = 4'(k);
                e.cap = (w[23:18] != 6'd0);
                if (w != 32'd0 && (e.cap == (pass == 0)))
                    q.push_back(e);
            end
        end
    endtask

    task automatic check_head();
        check("valid", 64'(out_valid), 64'(1));
        check("dir", 64'(out_dir), 64'(q[0].dir));
        check("move", 64'(out_move), 64'(q[0].mv));
        check("cap", 64'(out_capture), 64'(q[0].cap));
    endtask

    task automatic accept_bundle(input logic [511:0] b, input bit last);
        build_expect(b);
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'(1));
        check("idle_out_valid", 64'(out_valid), 64'(0));
        in_valid = 1'b1;
        in_moves = b;
        in_last  = last;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: rdy_pat
    task automatic send_bundle(input logic [511:0] b, input bit last,
                               input int mode);
        int cyc;
        int pi;
        cyc = 0;
        pi  = 0;
        accept_bundle(b, last);
        while (q.size() > 0) begin
            check_head();
            check("drain_in_ready", 64'(in_ready), 64'(0));
            check("drain_done", 64'(list_done), 64'(0));
            check("drain_count", 64'(move_count), 64'(model_cnt));
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1));
                default: out_ready = rdy_pat[pi[4:0]];
            endcase
            if (pi < 31) pi++;
            if (out_ready && out_valid) begin
                void'(q.pop_front());
                bump();
            end
            @(negedge clk);
            cyc++;
            if (cyc > 200) begin
                check("drain_timeout", 64'(0), 64'(1));
                q.delete();
            end
        end
        out_ready = 1'b0;
        check("post_out_valid", 64'(out_valid), 64'(0));
        if (last) begin
            check("list_done", 64'(list_done), 64'(1));
            check("move_count", 64'(move_count), 64'(model_cnt));
            model_cnt = 0;
        end else begin
            check("no_done", 64'(list_done), 64'(0));
            check("back_idle", 64'(in_ready), 64'(1));
        end
    endtask

    function automatic logic [511:0] rand_bundle(input int p_move);
        logic [511:0] b;
        for (int k = 0; k < 16; k++)
            b[k*32 +: 32] = rand_word(p_move, 1'($urandom_range(1)));
        return b;
    endfunction

    function automatic logic [511:0] two_moves();
        logic [511:0] b;
        int i, j;
        b = '0;
        i = int'($urandom_range(15));
        j = (i + int'($urandom_range(15, 1))) % 16;
        b[i*32 +: 32] = rand_word(100, 1'($urandom_range(1)));
        b[j*32 +: 32] = rand_word(100, 1'($urandom_range(1)));
        return b;
    endfunction

    logic [511:0] dir_b;
    logic [511:0] lin_b;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_moves = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_move", 64'(out_move), 64'(0));
        check("rst_out_dir", 64'(out_dir), 64'(0));
        check("rst_done", 64'(list_done), 64'(0));
        check("rst_count", 64'(move_count), 64'(0));
        rst_n = 1'b1;

        dir_b = '0;
        dir_b[0*32 +: 32] = 32'h0000_1234;
        dir_b[7*32 +: 32] = 32'h0002_1010;
        dir_b[8*32 +: 32] = 32'h00C1_0A05;
        send_bundle(dir_b, 1'b0, 0);
        send_bundle(dir_b, 1'b0, 2);
        send_bundle('0, 1'b0, 0);
        send_bundle('0, 1'b1, 0);

        for (int n = 0; n < 64; n++)
            send_bundle(two_moves(), n == 63, 1);
        for (int n = 0; n < 3; n++)
            send_bundle(two_moves(), n == 2, 1);

        send_bundle(rand_bundle(50), 1'b0, 1);
        lin_b = '0;
        for (int k = 0; k < 5; k++)
            lin_b[k*32 +: 32] = 32'(k + 1);
        accept_bundle(lin_b, 1'b0);
        for (int n = 0; n < 2; n++) begin
            check_head();
            out_ready = 1'b1;
            void'(q.pop_front());
            bump();
            @(negedge clk);
        end
        check_head();
        out_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_cnt = 0;
        q.delete();
        check("flush_valid", 64'(out_valid), 64'(0));
        check("flush_ready", 64'(in_ready), 64'(1));
        check("flush_count", 64'(move_count), 64'(0));
        check("flush_done", 64'(list_done), 64'(0));
        @(negedge clk);
        check("flush_done2", 64'(list_done), 64'(0));

        for (int n = 0; n < 20; n++)
            send_bundle(rand_bundle(100), n == 19, 0);

        for (int s = 0; s < 6; s++) begin
            int nb;
            nb = int'($urandom_range(5, 1));
            for (int n = 0; n < nb; n++)
                send_bundle(rand_bundle(int'($urandom_range(100))),
                            n == nb - 1, 1);
        end

        lin_b = '0;
        for (int k = 0; k < 6; k++)
            lin_b[k*32 +: 32] = 32'h100 + 32'(k);
        accept_bundle(lin_b, 1'b0);
        out_ready = 1'b1;
        check_head();
        @(negedge clk);
        out_ready = 1'b0;
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'(0));
        check("arst_move", 64'(out_move), 64'(0));
        check("arst_dir", 64'(out_dir), 64'(0));
        check("arst_cap", 64'(out_capture), 64'(0));
        check("arst_done", 64'(list_done), 64'(0));
        check("arst_count", 64'(move_count), 64'(0));
        check("arst_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        model_cnt = 0;
        q.delete();
        send_bundle(dir_b, 1'b1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
